// File: rtl/hsi_m_tx_ctrl_if.sv
// Byte-stream and line-pair bundle between the command FIFO side and the HSI master transmitter.
// The master modport is the transmitter's view; slave is the feeding/observing side.
interface hsi_m_tx_ctrl_if;
    logic       clk_en;
    logic [7:0] d;
    logic       d_vld;
    logic       d_last;
    logic       d_ack;
    logic       com1;
    logic       com2;
    logic       busy;
    logic       tx_frame_end;
    logic       tx_underrun;

    modport master (
        input  clk_en, d, d_vld, d_last,
        output d_ack, com1, com2, busy, tx_frame_end, tx_underrun
    );

    modport slave (
        output clk_en, d, d_vld, d_last,
        input  d_ack, com1, com2, busy, tx_frame_end, tx_underrun
    );
endinterface

// File: rtl/hsi_m_tx_ctrl.sv
// HSI master command transmitter: 8 data bits MSB first plus odd parity per byte on com1/com2,
// each bit cell a HI then LO phase of one clk_en tick, frames closed by a 2*GAP_BITS-tick idle gap.
module hsi_m_tx_ctrl #(
    parameter int GAP_BITS = 4
) (
    input  logic            clk,
    input  logic            n_rst,
    hsi_m_tx_ctrl_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HI   = 2'd1;
    localparam logic [1:0] S_LO   = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    // Gap counter is loaded on the entering tick, so the final tick sees zero.
    localparam logic [4:0] GAP_LAST = 5'(2 * GAP_BITS - 1);

    logic [1:0] r_state;
    logic [3:0] r_bitcnt;
    logic [8:0] r_shift;
    logic       r_last;
    logic [4:0] r_gapcnt;
    logic       r_com1;
    logic       r_com2;
    logic       r_busy;
    logic       r_d_ack;
    logic       r_frame_end;
    logic       r_underrun;

    logic w_boundary;
    logic w_after_byte;
    logic w_fetch;
    logic w_gap_enter;
    logic w_underrun;
    logic w_gap_done;

    always_comb begin
        w_after_byte = (r_state == S_LO) && (r_bitcnt == 4'd8);
        w_boundary   = bus.clk_en && ((r_state == S_IDLE) || w_after_byte);
        w_fetch      = w_boundary && bus.d_vld && !(w_after_byte && r_last);
        w_gap_enter  = w_boundary && w_after_byte && !w_fetch;
        w_underrun   = w_gap_enter && !r_last;
        w_gap_done   = bus.clk_en && (r_state == S_GAP) && (r_gapcnt == 5'd0);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_bitcnt    <= 4'd0;
            r_shift     <= 9'd0;
            r_last      <= 1'b0;
            r_gapcnt    <= 5'd0;
            r_com1      <= 1'b0;
            r_com2      <= 1'b0;
            r_busy      <= 1'b0;
            r_d_ack     <= 1'b0;
            r_frame_end <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_d_ack     <= w_fetch;
            r_underrun  <= w_underrun;
            r_frame_end <= w_gap_done;
            if (w_fetch) begin
                // Parity bit rides at the LSB so it leaves last; bit 7 goes out on this same tick.
                r_state  <= S_HI;
                r_shift  <= {bus.d, ~^bus.d};
                r_last   <= bus.d_last;
                r_bitcnt <= 4'd0;
                r_com1   <= bus.d[7];
                r_com2   <= ~bus.d[7];
                r_busy   <= 1'b1;
            end else if (w_gap_enter) begin
                r_state  <= S_GAP;
                r_gapcnt <= GAP_LAST;
            end else if (bus.clk_en) begin
                case (r_state)
                    S_HI: begin
                        r_state <= S_LO;
                        r_com1  <= 1'b0;
                        r_com2  <= 1'b0;
                    end
                    S_LO: begin
                        r_state  <= S_HI;
                        r_bitcnt <= r_bitcnt + 4'd1;
                        r_shift  <= {r_shift[7:0], 1'b0};
                        r_com1   <= r_shift[7];
                        r_com2   <= ~r_shift[7];
                    end
                    S_GAP: begin
                        if (r_gapcnt == 5'd0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_gapcnt <= r_gapcnt - 5'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.d_ack        = r_d_ack;
    assign bus.com1         = r_com1;
    assign bus.com2         = r_com2;
    assign bus.busy         = r_busy;
    assign bus.tx_frame_end = r_frame_end;
    assign bus.tx_underrun  = r_underrun;
endmodule
